// File: rtl/edac_pkg.sv
// edac_pkg: constants, codeword layout tables, field typedefs and helper
// functions shared by the EDAC encoder and decoder.
package edac_pkg;

    localparam int CW_W     = 32;          // protected word width
    localparam int DATA_W   = 8;           // payload width (CRC width matches)
    localparam int CNT_W    = 16;          // error counter width
    localparam int CODE_W   = 21;          // Hamming codeword width inside the word
    localparam int SYND_W   = 5;           // syndrome width
    localparam int SYND_MAX = 21;          // largest correctable syndrome
    localparam int CRC_T_W  = 2 * DATA_W;  // width of the division working registers

    // Bit index b carries Hamming position b+1.
    localparam logic [4:0][4:0] PARITY_POS = {5'd15, 5'd7, 5'd3, 5'd1, 5'd0};
    localparam logic [7:0][4:0] CRC_POS    = {5'd11, 5'd10, 5'd9, 5'd8, 5'd6, 5'd5, 5'd4, 5'd2};
    localparam logic [7:0][4:0] DATA_POS   = {5'd20, 5'd19, 5'd18, 5'd17, 5'd16, 5'd14, 5'd13, 5'd12};

    typedef logic [CODE_W-1:0] code_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [SYND_W-1:0] synd_t;

    typedef struct packed {
        logic [CW_W-CODE_W-1:0] pad;   // must be zero in a well-formed word
        code_t                  code;
    } word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SYND = 2'd1,
        ST_CRC  = 2'd2,
        ST_OUT  = 2'd3
    } state_t;

    // Syndrome bit j is the parity check covered by the parity bit at
    // PARITY_POS[j] (Hamming position 2^j).
    function automatic synd_t calc_syndrome(input code_t c);
        synd_t s;
        s = '0;
        for (int j = 0; j < SYND_W; j++) begin
            for (int b = 0; b < CODE_W; b++) begin
                if (((b + 1) & (int'(PARITY_POS[j]) + 1)) != 0) begin
                    s[j] = s[j] ^ c[b];
                end
            end
        end
        return s;
    endfunction

    function automatic data_t get_data(input code_t c);
        data_t d;
        for (int i = 0; i < DATA_W; i++) begin
            d[i] = c[DATA_POS[i]];
        end
        return d;
    endfunction

    function automatic data_t get_crc(input code_t c);
        data_t r;
        for (int i = 0; i < DATA_W; i++) begin
            r[i] = c[CRC_POS[i]];
        end
        return r;
    endfunction

endpackage

// File: rtl/edac_crc_step.sv
// edac_crc_step: one combinational step of the bit-serial CRC division.
// If bit k of the working remainder is set the shifted polynomial is XORed
// in; the polynomial always moves one place right for the next step.
module edac_crc_step
    import edac_pkg::*;
(
    input  logic [CRC_T_W-1:0] t,
    input  logic [CRC_T_W-1:0] p,
    input  logic [3:0]         k,
    output logic [CRC_T_W-1:0] t_next,
    output logic [CRC_T_W-1:0] p_next
);

    // Conditional subtract (XOR) of the aligned polynomial, then realign.
    always_comb begin
        t_next = t[k] ? (t ^ p) : t;
        p_next = p >> 1;
    end

endmodule

// File: rtl/edac_decoder.sv
// edac_decoder: recovers the 8-bit payload from a 32-bit EDAC word.
// Flow per word: capture -> Hamming syndrome/correction -> 8 serial CRC
// steps -> hold result until the consumer takes it.
// Optional error counters are built when EDAC_ERR_CNT_EN is defined.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high; valid, once raised, stays high with stable data until that
// edge, and ready may be given independently of valid.
module edac_decoder
    import edac_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              din_valid,
    output logic              din_ready,
    input  logic [CW_W-1:0]   din,
    input  logic [DATA_W-1:0] crc_poly,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [DATA_W-1:0] dout,
    output logic [SYND_W-1:0] syndrome,
    output logic              err_corr,
    output logic              err_uncorr,
    output logic              err_crc,
    output logic              err_fmt,
    output logic [1:0]        fsm_state
`ifdef EDAC_ERR_CNT_EN
    ,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt
`endif
);

    state_t              state_q, state_d;
    word_t               word_q;
    logic [DATA_W-1:0]   poly_q;
    synd_t               synd_c, synd_q;
    code_t               code_fix;
    logic [DATA_W-1:0]   data_q, crc_rx_q;
    logic                corr_q, unc_q, fmt_q;
    logic [CRC_T_W-1:0]  t_q, p_q, t_n, p_n;
    logic [2:0]          cnt_q;
    logic [3:0]          step_k;

    assign din_ready  = (state_q == ST_IDLE);
    assign dout_valid = (state_q == ST_OUT);
    assign fsm_state  = state_q;

    // Steps walk the remainder from its top bit (15) down to bit 8.
    assign step_k = 4'd15 - {1'b0, cnt_q};

    edac_crc_step u_crc_step (
        .t      (t_q),
        .p      (p_q),
        .k      (step_k),
        .t_next (t_n),
        .p_next (p_n)
    );

    // Syndrome of the captured word and its single-bit correction.
    always_comb begin
        synd_c   = calc_syndrome(word_q.code);
        code_fix = word_q.code;
        if (synd_c != '0 && synd_c <= synd_t'(SYND_MAX)) begin
            code_fix = word_q.code ^ (code_t'(1) << (synd_c - 5'd1));
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: strictly one word in flight.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (din_valid) state_d = ST_SYND;
            ST_SYND: state_d = ST_CRC;
            ST_CRC:  if (cnt_q == 3'd7) state_d = ST_OUT;
            ST_OUT:  if (dout_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath: capture, decode, serial CRC, and result registers that only
    // change on the step that enters OUT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q     <= '0;
            poly_q     <= '0;
            synd_q     <= '0;
            data_q     <= '0;
            crc_rx_q   <= '0;
            corr_q     <= 1'b0;
            unc_q      <= 1'b0;
            fmt_q      <= 1'b0;
            t_q        <= '0;
            p_q        <= '0;
            cnt_q      <= '0;
            dout       <= '0;
            syndrome   <= '0;
            err_corr   <= 1'b0;
            err_uncorr <= 1'b0;
            err_crc    <= 1'b0;
            err_fmt    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (din_valid) begin
                        word_q <= din;
                        poly_q <= crc_poly;
                    end
                end
                ST_SYND: begin
                    synd_q   <= synd_c;
                    data_q   <= get_data(code_fix);
                    crc_rx_q <= get_crc(code_fix);
                    corr_q   <= (synd_c != '0) && (synd_c <= synd_t'(SYND_MAX));
                    unc_q    <= (synd_c > synd_t'(SYND_MAX));
                    fmt_q    <= |word_q.pad;
                    t_q      <= {get_data(code_fix), 8'h00};
                    p_q      <= {poly_q, 8'h00};
                    cnt_q    <= '0;
                end
                ST_CRC: begin
                    t_q   <= t_n;
                    p_q   <= p_n;
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        dout       <= data_q;
                        syndrome   <= synd_q;
                        err_corr   <= corr_q;
                        err_uncorr <= unc_q;
                        err_fmt    <= fmt_q;
                        err_crc    <= (t_n[DATA_W-1:0] != crc_rx_q);
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef EDAC_ERR_CNT_EN
    // Saturating error counters, bumped once per delivered result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
        end else if (dout_valid && dout_ready) begin
            if (err_corr && corr_cnt != '1) begin
                corr_cnt <= corr_cnt + 1'b1;
            end
            if ((err_uncorr || err_crc) && uncorr_cnt != '1) begin
                uncorr_cnt <= uncorr_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_edac_decoder.sv
// tb_edac_decoder: directed and random words through edac_decoder, checked
// against a position-table reference model of the decoding rules.
`timescale 1ns/1ps
module tb_edac_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        din_valid = 1'b0;
    logic        din_ready;
    logic [31:0] din = '0;
    logic [7:0]  crc_poly = '0;
    logic        dout_valid;
    logic        dout_ready = 1'b0;
    logic [7:0]  dout;
    logic [4:0]  syndrome;
    logic        err_corr, err_uncorr, err_crc, err_fmt;
    logic [1:0]  fsm_state;
`ifdef EDAC_ERR_CNT_EN
    logic [15:0] corr_cnt, uncorr_cnt;
    int          exp_corr = 0;
    int          exp_unc  = 0;
`endif

    int          vectors = 0;
    int          miscompares = 0;
    logic [16:0] exp_q[$];

    localparam int DPOS[8] = '{12, 13, 14, 16, 17, 18, 19, 20};
    localparam int CPOS[8] = '{2, 4, 5, 6, 8, 9, 10, 11};

    edac_decoder dut (
        .clk        (clk),
        .rst        (rst),
        .din_valid  (din_valid),
        .din_ready  (din_ready),
        .din        (din),
        .crc_poly   (crc_poly),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout       (dout),
        .syndrome   (syndrome),
        .err_corr   (err_corr),
        .err_uncorr (err_uncorr),
        .err_crc    (err_crc),
        .err_fmt    (err_fmt),
        .fsm_state  (fsm_state)
`ifdef EDAC_ERR_CNT_EN
        ,
        .corr_cnt   (corr_cnt),
        .uncorr_cnt (uncorr_cnt)
`endif
    );

    // Clock.
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // CRC by the division rule, using plain integer arithmetic.
    function automatic logic [7:0] crc_ref(input logic [7:0] d, input logic [7:0] poly);
        int t;
        int p;
        t = int'(d) * 256;
        p = int'(poly) * 256;
        for (int k = 15; k >= 8; k--) begin
            if (((t >> k) & 1) == 1) t = t ^ p;
            p = p >> 1;
        end
        return 8'(t & 255);
    endfunction

    // Builds a clean word: place data and CRC, then choose parity bits so
    // the syndrome becomes zero.
    function automatic logic [31:0] encode(input logic [7:0] d, input logic [7:0] poly);
        logic [31:0] w;
        logic [7:0]  c;
        int          s;
        w = '0;
        c = crc_ref(d, poly);
        for (int i = 0; i < 8; i++) begin
            w[DPOS[i]] = d[i];
            w[CPOS[i]] = c[i];
        end
        s = 0;
        for (int b = 0; b < 21; b++) if (w[b]) s = s ^ (b + 1);
        for (int j = 0; j < 5; j++) if (((s >> j) & 1) == 1) w[(1 << j) - 1] = 1'b1;
        return w;
    endfunction

    // Expected {dout, syndrome, err_corr, err_uncorr, err_crc, err_fmt}.
    function automatic logic [16:0] ref_model(input logic [31:0] w, input logic [7:0] poly);
        int          s;
        logic [20:0] cw;
        logic [7:0]  d, c;
        logic        corr, unc;
        s = 0;
        for (int b = 0; b < 21; b++) if (w[b]) s = s ^ (b + 1);
        cw   = w[20:0];
        corr = (s >= 1) && (s <= 21);
        unc  = (s > 21);
        if (corr) cw[s-1] = ~cw[s-1];
        for (int i = 0; i < 8; i++) begin
            d[i] = cw[DPOS[i]];
            c[i] = cw[CPOS[i]];
        end
        return {d, 5'(s), corr, unc, (crc_ref(d, poly) != c), (w[31:21] != 11'd0)};
    endfunction

    // Driver: send one word, measure latency, hold off the consumer for
    // 'hold' cycles, then complete the output handshake.
    task automatic run_word(input logic [31:0] w, input logic [7:0] poly, input int hold,
                            output logic [16:0] got);
        logic [16:0] exp;
        int          cyc;
        exp_q.push_back(ref_model(w, poly));
        @(negedge clk);
        check("din_ready_idle", 32'(din_ready), 32'd1);
        din       = w;
        crc_poly  = poly;
        din_valid = 1'b1;
        @(negedge clk);
        check("din_ready_busy", 32'(din_ready), 32'd0);
        // Keep offering junk while busy; it must be ignored.
        din      = $urandom;
        crc_poly = 8'($urandom);
        cyc = 0;
        while (dout_valid !== 1'b1 && cyc < 30) begin
            @(negedge clk);
            cyc++;
        end
        check("latency", 32'(cyc), 32'd9);
        got = {dout, syndrome, err_corr, err_uncorr, err_crc, err_fmt};
        exp = exp_q.pop_front();
        check("dout", 32'(got[16:9]), 32'(exp[16:9]));
        check("syndrome", 32'(got[8:4]), 32'(exp[8:4]));
        check("flags", 32'(got[3:0]), 32'(exp[3:0]));
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_stable",
                  32'({dout_valid, din_ready, dout, syndrome, err_corr, err_uncorr, err_crc, err_fmt}),
                  32'({1'b1, 1'b0, got}));
        end
        dout_ready = 1'b1;
        @(negedge clk);
        dout_ready = 1'b0;
        din_valid  = 1'b0;
        check("after_handshake", 32'({dout_valid, din_ready}), 32'({1'b0, 1'b1}));
`ifdef EDAC_ERR_CNT_EN
        if (exp[3]) exp_corr++;
        if (exp[2] || exp[1]) exp_unc++;
        check("corr_cnt", 32'(corr_cnt), 32'(exp_corr));
        check("uncorr_cnt", 32'(uncorr_cnt), 32'(exp_unc));
`endif
    endtask

    initial begin
        logic [16:0] got;
        logic [31:0] w;
        logic [7:0]  poly;
        int          kind;
        int          b1, b2;
        int          seen_valid;

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_din_ready", 32'(din_ready), 32'd1);
        check("rst_outputs",
              32'({dout_valid, dout, syndrome, err_corr, err_uncorr, err_crc, err_fmt}), 32'd0);
        rst = 1'b0;

        // Clean word.
        run_word(32'h0000_0000, 8'h07, 0, got);
        check("clean_dir", 32'(got), 32'({8'h00, 5'd0, 4'b0000}));

        // Single-bit error at position 13.
        run_word(32'h0000_1000, 8'h07, 0, got);
        check("single_dir", 32'(got), 32'({8'h00, 5'd13, 4'b1000}));

        // Uncorrectable syndrome 23; CRC recomputed over 0x80 is 0x2A.
        run_word(32'h0010_0002, 8'h07, 0, got);
        check("uncorr_dir", 32'(got), 32'({8'h80, 5'd23, 4'b0110}));

        // Backpressure: consumer stalls for 5 cycles.
        run_word(32'h0000_0000, 8'h07, 5, got);
        check("backpressure_dir", 32'(got), 32'({8'h00, 5'd0, 4'b0000}));

        // Format error.
        run_word(32'h8000_0000, 8'h07, 0, got);
        check("fmt_dir", 32'(got), 32'({8'h00, 5'd0, 4'b0001}));

        // Reset in the middle of the CRC phase.
        @(negedge clk);
        din       = encode(8'h5A, 8'h31);
        crc_poly  = 8'h31;
        din_valid = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_outputs",
              32'({dout_valid, dout, syndrome, err_corr, err_uncorr, err_crc, err_fmt}), 32'd0);
        check("midrst_din_ready", 32'(din_ready), 32'd1);
`ifdef EDAC_ERR_CNT_EN
        exp_corr = 0;
        exp_unc  = 0;
        check("midrst_cnt", 32'({corr_cnt, uncorr_cnt}), 32'd0);
`endif
        seen_valid = 0;
        repeat (12) begin
            @(negedge clk);
            if (dout_valid !== 1'b0) seen_valid++;
        end
        check("midrst_no_output", 32'(seen_valid), 32'd0);
        run_word(encode(8'hA5, 8'h1D), 8'h1D, 1, got);
        check("post_rst_dir", 32'(got), 32'({8'hA5, 5'd0, 4'b0000}));

        // Three corrected single-bit errors.
        for (int i = 0; i < 3; i++) begin
            poly = 8'($urandom);
            w    = encode(8'($urandom), poly);
            b1   = $urandom_range(0, 20);
            w[b1] = ~w[b1];
            run_word(w, poly, 0, got);
        end
`ifdef EDAC_ERR_CNT_EN
        check("corr_cnt_three", 32'(corr_cnt), 32'd3);
`endif

        // Random mix of clean, single, double, raw and malformed words.
        for (int n = 0; n < 24; n++) begin
            kind = $urandom_range(0, 4);
            poly = 8'($urandom);
            w    = encode(8'($urandom), poly);
            b1   = $urandom_range(0, 20);
            b2   = (b1 + $urandom_range(1, 20)) % 21;
            case (kind)
                1: w[b1] = ~w[b1];
                2: begin w[b1] = ~w[b1]; w[b2] = ~w[b2]; end
                3: w = {11'd0, 21'($urandom)};
                4: begin w[b1] = ~w[b1]; w[31:21] = 11'($urandom_range(1, 2047)); end
                default: ;
            endcase
            run_word(w, poly, $urandom_range(0, 3), got);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
